// File: rtl/psram_pkg.sv
// psram_pkg: shared state encoding, burst length and descriptor layout for the task-table SRAM responder
package psram_pkg;
  typedef enum logic [3:0] {IDLE, HOST, HRSP, DBURST, DDRAIN, DWAIT} state_t;
  localparam int BURST_LEN_DEF = 4;
  localparam int CFG0 = 0;
  localparam int CFG1 = 1;
  localparam int CFG2 = 2;
  localparam int CFG3 = 3;
  localparam int CHAIN_EN_BIT = 0;
  localparam int CHAIN_ADDR_LSB = 1;
  localparam int CHAIN_ADDR_MSB = 17;
endpackage

// File: rtl/psram_tbl_arb.sv
// psram_tbl_arb: two-way round-robin between host and DMA, favouring whichever side was not served last
module psram_tbl_arb
  import psram_pkg::*;
(
  input  logic clk,
  input  logic rstn,
  input  logic host_req,
  input  logic dma_req,
  input  logic served_host,
  input  logic served_dma,
  output logic grant_host,
  output logic grant_dma
);
  logic last_dma;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) last_dma <= 1'b0;
    else if (served_dma) last_dma <= 1'b1;
    else if (served_host) last_dma <= 1'b0;
  assign grant_dma  = dma_req & (~host_req | ~last_dma);
  assign grant_host = host_req & (~dma_req | last_dma);
endmodule

// File: rtl/psram_dma_tbl.sv
// psram_dma_tbl: serves DMA descriptor bursts and host register accesses from one single-port table SRAM
module psram_dma_tbl
  import psram_pkg::*;
#(
  parameter int ADDR_W    = 17,
  parameter int SRAM_AW   = 10,
  parameter int BURST_LEN = BURST_LEN_DEF
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               ram_rd_req,
  output logic               ram_rd_ack,
  input  logic [ADDR_W-1:0]  ram_addr,
  output logic [31:0]        ram_rdata,
  input  logic               host_req,
  input  logic               host_we,
  input  logic [ADDR_W-1:0]  host_addr,
  input  logic [31:0]        host_wdata,
  output logic               host_ack,
  output logic [31:0]        host_rdata,
  output logic               sram_cs,
  output logic               sram_we,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [31:0]        sram_wdata,
  input  logic [31:0]        sram_rdata,
  output logic               oor_err,
  input  logic               oor_clr
);
  localparam int CW = $clog2(BURST_LEN + 1);
  state_t state, next;
  logic [ADDR_W-1:0] base;
  logic [CW-1:0] icnt;
  logic [ADDR_W:0] daddr;
  logic pend_v, pend_oor, h_rd, issue, served_dma, served_host, grant_dma, grant_host, dma_oor, host_oor;
  // one extra bit so base+icnt overflow shows up as out of range instead of wrapping
  assign daddr    = {1'b0, base} + {{(ADDR_W + 1 - CW){1'b0}}, icnt};
  assign dma_oor  = |daddr[ADDR_W:SRAM_AW];
  assign host_oor = |host_addr[ADDR_W-1:SRAM_AW];
  psram_tbl_arb u_arb (
    .clk(clk), .rstn(rstn), .host_req(host_req), .dma_req(ram_rd_req),
    .served_host(served_host), .served_dma(served_dma),
    .grant_host(grant_host), .grant_dma(grant_dma)
  );
  always_comb begin
    next        = state;
    sram_cs     = 1'b0;
    sram_we     = 1'b0;
    sram_addr   = '0;
    sram_wdata  = '0;
    issue       = 1'b0;
    served_dma  = 1'b0;
    served_host = 1'b0;
    case (state)
      IDLE:   next = grant_dma ? DBURST : grant_host ? HOST : IDLE;
      HOST: begin
        sram_cs    = ~host_oor;
        sram_we    = host_we & ~host_oor;
        sram_addr  = host_addr[SRAM_AW-1:0];
        sram_wdata = host_wdata;
        next       = HRSP;
      end
      HRSP: begin
        served_host = 1'b1;
        next        = IDLE;
      end
      DBURST: begin
        issue      = ram_rd_req;
        served_dma = ~ram_rd_req;
        sram_cs    = ram_rd_req & ~dma_oor;
        sram_addr  = daddr[SRAM_AW-1:0];
        next       = !ram_rd_req ? IDLE : (icnt == CW'(BURST_LEN - 1)) ? DDRAIN : DBURST;
      end
      DDRAIN: begin
        served_dma = 1'b1;
        next       = ram_rd_req ? DWAIT : IDLE;
      end
      DWAIT:  next = ram_rd_req ? DWAIT : IDLE;
      default: next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state    <= IDLE;
      base     <= '0;
      icnt     <= '0;
      pend_v   <= 1'b0;
      pend_oor <= 1'b0;
      h_rd     <= 1'b0;
      oor_err  <= 1'b0;
    end else begin
      state    <= next;
      if (state == IDLE && grant_dma) base <= ram_addr;
      icnt     <= issue ? icnt + 1'b1 : '0;
      pend_v   <= issue;
      pend_oor <= dma_oor;
      h_rd     <= (state == HOST) & ~host_we & ~host_oor;
      oor_err  <= ((state == HOST) & host_oor) | (issue & dma_oor) | (oor_err & ~oor_clr);
    end
  // a dropped request also kills the ack of the read already in flight
  assign ram_rd_ack = pend_v & ram_rd_req;
  assign ram_rdata  = (ram_rd_ack & ~pend_oor) ? sram_rdata : '0;
  assign host_ack   = state == HRSP;
  assign host_rdata = (host_ack & h_rd) ? sram_rdata : '0;
endmodule

// File: tb/tb_psram_dma_tbl.sv
// tb_psram_dma_tbl: directed tests of the table SRAM responder against a behavioural SRAM
module tb_psram_dma_tbl;
  logic clk = 1'b0, rstn = 1'b0;
  logic ram_rd_req = 1'b0, ram_rd_ack, host_req = 1'b0, host_we = 1'b0, host_ack;
  logic sram_cs, sram_we, oor_err, oor_clr = 1'b0;
  logic [16:0] ram_addr = '0, host_addr = '0;
  logic [31:0] ram_rdata, host_wdata = '0, host_rdata, sram_wdata, sram_rdata;
  logic [9:0] sram_addr;
  logic [31:0] mem [0:1023];
  logic [31:0] ad [0:7];
  int ac [0:7];
  int na, dcs;
  int n_chk = 0, n_fail = 0, cs_cnt = 0;

  psram_dma_tbl dut (
    .clk(clk), .rstn(rstn), .ram_rd_req(ram_rd_req), .ram_rd_ack(ram_rd_ack),
    .ram_addr(ram_addr), .ram_rdata(ram_rdata), .host_req(host_req), .host_we(host_we),
    .host_addr(host_addr), .host_wdata(host_wdata), .host_ack(host_ack), .host_rdata(host_rdata),
    .sram_cs(sram_cs), .sram_we(sram_we), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata), .oor_err(oor_err), .oor_clr(oor_clr)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (sram_cs) begin
      cs_cnt <= cs_cnt + 1;
      if (sram_we) mem[sram_addr] <= sram_wdata;
      else sram_rdata <= mem[sram_addr];
    end

  task automatic host_access(input logic we, input logic [16:0] a, input logic [31:0] wd,
                             output logic [31:0] rd, output int lat);
    host_req = 1'b1; host_we = we; host_addr = a; host_wdata = wd; lat = -1; rd = '0;
    for (int i = 0; i < 10 && lat < 0; i++) begin
      @(negedge clk);
      if (host_ack) begin lat = i; rd = host_rdata; end
    end
    host_req = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic dma_run(input logic [16:0] a, input int stop_after, input int cycles);
    na = 0; dcs = 0; ram_addr = a; ram_rd_req = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (ram_rd_ack && na < 8) begin ad[na] = ram_rdata; ac[na] = i; na++; end
      if (ram_rd_req && (stop_after > 0 ? na == stop_after : i == cycles - 3)) begin
        ram_rd_req = 1'b0; dcs = cs_cnt;
      end
    end
    ram_rd_req = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic check_zero(input string name);
    logic [161:0] v;
    v = {ram_rd_ack, ram_rdata, host_ack, host_rdata, sram_cs, sram_we, sram_addr, sram_wdata, oor_err};
    n_chk++;
    if (v !== '0) begin n_fail++; $display("FAIL %s: outputs=%h required all zero", name, v); end
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1 check_zero("reset_outputs");
    rstn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_both(input int exp_h, input int exp_d);
    int hl;
    hl = -1; na = 0;
    host_req = 1'b1; host_we = 1'b1; host_addr = 17'h10; host_wdata = 32'h1234;
    ram_addr = 17'h100; ram_rd_req = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (host_ack && hl < 0) begin hl = i; host_req = 1'b0; end
      if (ram_rd_ack && na < 8) begin ac[na] = i; na++; end
      if (i == 9) ram_rd_req = 1'b0;
    end
    host_req = 1'b0;
    @(posedge clk); #1;
    n_chk++; if (hl != exp_h) begin n_fail++; $display("FAIL arb_host_ack: cycle %0d required %0d", hl, exp_h); end
    n_chk++; if (ac[0] != exp_d) begin n_fail++; $display("FAIL arb_dma_first: cycle %0d required %0d", ac[0], exp_d); end
    n_chk++; if (na != 4) begin n_fail++; $display("FAIL arb_dma_acks: got %0d required 4", na); end
  endtask

  task automatic test_arb;
    test_both(12, 2);
    dma_run(17'h100, 0, 12);
    test_both(2, 5);
  endtask

  task automatic test_preload;
    logic [31:0] rd;
    int lat;
    for (int k = 0; k < 5; k++) begin
      host_access(1'b1, 17'h100 + 17'(k), 32'hA0 + 32'(k), rd, lat);
      n_chk++; if (lat != 2) begin n_fail++; $display("FAIL preload_lat: %0d required 2", lat); end
    end
    host_access(1'b1, 17'h3FE, 32'hDEAD03FE, rd, lat);
    host_access(1'b1, 17'h3FF, 32'hDEAD03FF, rd, lat);
  endtask

  task automatic test_host_rw;
    logic [31:0] rd;
    int lat, c0;
    c0 = cs_cnt;
    host_access(1'b1, 17'h7, 32'h55AA_00FF, rd, lat);
    n_chk++; if (lat != 2) begin n_fail++; $display("FAIL host_wr_lat: %0d required 2", lat); end
    n_chk++; if (rd !== 32'h0) begin n_fail++; $display("FAIL host_wr_rdata: %h required 0", rd); end
    host_access(1'b0, 17'h7, 32'h0, rd, lat);
    n_chk++; if (lat != 2) begin n_fail++; $display("FAIL host_rd_lat: %0d required 2", lat); end
    n_chk++; if (rd !== 32'h55AA_00FF) begin n_fail++; $display("FAIL host_rd_data: %h required 55aa00ff", rd); end
    n_chk++; if (cs_cnt - c0 != 2) begin n_fail++; $display("FAIL host_cs_count: %0d required 2", cs_cnt - c0); end
  endtask

  task automatic test_burst;
    int c0;
    c0 = cs_cnt;
    dma_run(17'h100, 0, 12);
    n_chk++; if (na != 4) begin n_fail++; $display("FAIL burst_acks: %0d required 4", na); end
    n_chk++; if (ac[0] != 2 || ac[3] != 5) begin n_fail++; $display("FAIL burst_timing: first %0d last %0d required 2 5", ac[0], ac[3]); end
    for (int k = 0; k < 4; k++) begin
      n_chk++;
      if (ad[k] !== 32'hA0 + 32'(k)) begin n_fail++; $display("FAIL burst_data%0d: %h required %h", k, ad[k], 32'hA0 + 32'(k)); end
    end
    n_chk++; if (cs_cnt - c0 != 4) begin n_fail++; $display("FAIL burst_cs_count: %0d required 4", cs_cnt - c0); end
  endtask

  task automatic test_abort;
    dma_run(17'h100, 2, 10);
    n_chk++; if (na != 2) begin n_fail++; $display("FAIL abort_acks: %0d required 2", na); end
    n_chk++; if (ad[1] !== 32'hA1) begin n_fail++; $display("FAIL abort_data1: %h required a1", ad[1]); end
    n_chk++; if (cs_cnt != dcs) begin n_fail++; $display("FAIL abort_cs_after_drop: %0d extra", cs_cnt - dcs); end
    dma_run(17'h104, 0, 12);
    n_chk++; if (na != 4 || ad[0] !== 32'hA4) begin n_fail++; $display("FAIL abort_next_burst: acks %0d data %h required 4 a4", na, ad[0]); end
  endtask

  task automatic test_oor;
    int c0;
    n_chk++; if (oor_err !== 1'b0) begin n_fail++; $display("FAIL oor_initial: %b required 0", oor_err); end
    c0 = cs_cnt;
    dma_run(17'h3FE, 0, 12);
    n_chk++; if (na != 4) begin n_fail++; $display("FAIL oor_acks: %0d required 4", na); end
    n_chk++; if (ad[0] !== 32'hDEAD03FE || ad[1] !== 32'hDEAD03FF) begin n_fail++; $display("FAIL oor_inrange_data: %h %h", ad[0], ad[1]); end
    n_chk++; if (ad[2] !== 32'h0 || ad[3] !== 32'h0) begin n_fail++; $display("FAIL oor_zero_data: %h %h required 0 0", ad[2], ad[3]); end
    n_chk++; if (cs_cnt - c0 != 2) begin n_fail++; $display("FAIL oor_cs_count: %0d required 2", cs_cnt - c0); end
    n_chk++; if (oor_err !== 1'b1) begin n_fail++; $display("FAIL oor_set: %b required 1", oor_err); end
    oor_clr = 1'b1;
    @(posedge clk); #1 oor_clr = 1'b0;
    n_chk++; if (oor_err !== 1'b0) begin n_fail++; $display("FAIL oor_clear: %b required 0", oor_err); end
    c0 = cs_cnt;
    host_req = 1'b1; host_we = 1'b0; host_addr = 17'h800;
    @(posedge clk); #1 oor_clr = 1'b1;
    @(posedge clk); #1 oor_clr = 1'b0;
    @(negedge clk);
    n_chk++; if (host_ack !== 1'b1 || host_rdata !== 32'h0) begin n_fail++; $display("FAIL oor_host_ack: ack %b data %h required 1 0", host_ack, host_rdata); end
    n_chk++; if (oor_err !== 1'b1) begin n_fail++; $display("FAIL oor_set_wins: %b required 1", oor_err); end
    n_chk++; if (cs_cnt != c0) begin n_fail++; $display("FAIL oor_host_cs: %0d cycles required 0", cs_cnt - c0); end
    host_req = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    na = 0; ram_addr = 17'h100; ram_rd_req = 1'b1;
    for (int i = 0; i < 10 && na < 3; i++) begin
      @(negedge clk);
      if (ram_rd_ack) na++;
    end
    n_chk++; if (na != 3) begin n_fail++; $display("FAIL rst_mid_reach: %0d acks required 3", na); end
    rstn = 1'b0;
    #1 check_zero("rst_mid_immediate");
    ram_rd_req = 1'b0;
    @(posedge clk); #1 check_zero("rst_mid_held");
    rstn = 1'b1;
    @(posedge clk); #1;
    dma_run(17'h100, 0, 12);
    n_chk++; if (na != 4 || ac[0] != 2) begin n_fail++; $display("FAIL rst_mid_reburst: acks %0d first %0d required 4 2", na, ac[0]); end
    n_chk++; if (ad[2] !== 32'hA2) begin n_fail++; $display("FAIL rst_mid_data2: %h required a2", ad[2]); end
  endtask

  initial begin
    test_reset;
    test_arb;
    test_preload;
    test_host_rw;
    test_burst;
    test_abort;
    test_oor;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/psram_dma_tbl.md
Name: psram_dma_tbl

Overview:
- Responder end of the DMA descriptor-fetch interface (ram_rd_req/ram_rd_ack/ram_addr/ram_rdata).
- Serves burst reads of task-table descriptors from a single-port synchronous SRAM holding the task table and chain descriptors.
- Shares that SRAM with a host register port, so firmware can load and inspect descriptors.
- Sits between psram_dma and the on-chip table SRAM macro.

Parameters:
- ADDR_W, 17: width of ram_addr and host_addr, in word addresses.
- SRAM_AW, 10: SRAM address width; DEPTH = 2**SRAM_AW words.
- BURST_LEN, 4: words returned per DMA request; one descriptor is cfg0..cfg3.

Ports:
- clk  in  1  clock
- rstn  in  1  reset
- ram_rd_req  in  1  DMA read request; level, held until the burst completes
- ram_rd_ack  out  1  one-cycle pulse; ram_rdata valid in the same cycle
- ram_addr  in  ADDR_W  burst start word address; sampled when the burst is accepted
- ram_rdata  out  32  read data
- host_req  in  1  host access request; level, held until host_ack
- host_we  in  1  1 = write, 0 = read
- host_addr  in  ADDR_W  host word address
- host_wdata  in  32  host write data
- host_ack  out  1  one-cycle completion pulse
- host_rdata  out  32  host read data; valid with host_ack
- sram_cs  out  1  SRAM chip select
- sram_we  out  1  SRAM write enable
- sram_addr  out  SRAM_AW  SRAM address
- sram_wdata  out  32  SRAM write data
- sram_rdata  in  32  SRAM read data, one cycle after cs with we=0
- oor_err  out  1  sticky out-of-range flag
- oor_clr  in  1  clears oor_err

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low (clk, rstn).
- Reset values: all outputs 0; FSM in IDLE; counters 0.
- FSM states: IDLE, HOST, HRSP, DBURST, DDRAIN, DWAIT.
- IDLE arbitration:
  - Only host_req pending: go to HOST.
  - Only ram_rd_req pending: latch base = ram_addr, go to DBURST.
  - Both pending: the side not served last wins (last_dma flag, reset 0, so DMA wins first).
- HOST (1 cycle): drive sram_cs=1, sram_we=host_we, sram_addr=host_addr[SRAM_AW-1:0], sram_wdata=host_wdata, then go to HRSP.
- HRSP (1 cycle):
  - host_ack=1; host_rdata = sram_rdata for reads, 0 for writes.
  - Set last_dma=0; go to IDLE.
  - Host latency: ack 2 cycles after host_req is sampled in IDLE.
- DBURST: each cycle issue an SRAM read at base+icnt, then increment icnt. When icnt == BURST_LEN-1 is issued, go to DDRAIN.
- Burst data return: for each read issued, the next cycle has ram_rd_ack=1 and ram_rdata = sram_rdata (registered).
  - Acks are back-to-back, BURST_LEN consecutive cycles.
  - The first ack comes 2 cycles after req is accepted.
- DDRAIN (1 cycle): deliver the last ack; set last_dma=1; go to DWAIT.
- DWAIT: hold until ram_rd_req == 0, then go to IDLE. Req held high after the burst never starts a second burst.
- Abort: ram_rd_req low during DBURST or DDRAIN:
  - Stop issuing at once.
  - Suppress the ack of the in-flight read.
  - Go to IDLE; set last_dma=1.
- Out of range: an address with bits above SRAM_AW nonzero, or base+icnt overflowing DEPTH:
  - No SRAM access for that word (sram_cs=0).
  - Still acknowledged, with ram_rdata=0 or host_rdata=0; host writes are dropped.
  - oor_err set 1 the cycle after the access.
- oor_clr clears oor_err. If a set and oor_clr occur in the same cycle, set wins.
- Address arithmetic: ADDR_W bits, no wrap-around; overflow of base+icnt is treated as out of range.
- sram_cs deasserts in every state without an access, so no idle SRAM reads occur.
- Host accesses are never interleaved inside a DMA burst. Max host wait: BURST_LEN+2 cycles plus the DMA's req-drop time.
- Reset mid-burst: everything returns to reset values; no ack is issued after rstn deasserts.

Decomposition:
- Shared package psram_pkg:
  - FSM state encoding constants (4-bit, matching the codebase's state width).
  - BURST_LEN default.
  - Descriptor word indices CFG0..CFG3.
  - Descriptor field positions in CFG3: chain_en bit 0, chain_addr bits 17:1.
- Optional sub-module psram_tbl_arb: a 2-way round-robin arbiter with the last_dma flag. The rest stays in one module.

Test Plan:
- Preload via host writes: 0x100..0x103 = 0xA0..0xA3. DMA req with ram_addr=0x100 -> acks on 4 consecutive cycles starting 2 cycles after req, ram_rdata 0xA0,0xA1,0xA2,0xA3; no 5th ack while req stays high.
- Host write 0x55AA_00FF to 0x7 then host read of 0x7 -> host_ack 2 cycles after each req; read returns 0x55AA_00FF; exactly 2 sram_cs cycles.
- host_req and ram_rd_req rise in the same cycle after reset -> DMA burst first (4 acks), then host served after DMA drops req. Repeat -> host first.
- DMA drops req after the 2nd ack -> no further acks; sram_cs low from that cycle; next req with ram_addr=0x104 returns the data at 0x104.
- ram_addr = 0x3FE with DEPTH=1024 -> words 0x3FE and 0x3FF return data, next two return 0 without sram_cs; oor_err=1. oor_clr -> 0; oor_clr in the same cycle as a new error -> stays 1.
- rstn asserted during the 3rd word of a burst -> all outputs 0 immediately; after release, a new burst behaves as in test 1.
